cr_kme_flag_packer: RTL

//  Downstream consumer of the KME 1-bit flag FIFO. Pops single-bit flags with a valid/ack handshake.

---
 rtl/cr_kme_flag_packer_if.sv | 54 +++++
 rtl/cr_kme_flag_packer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cr_kme_flag_packer_if.sv
// Bundles the FIFO pop side and the packed-word output side of the flag packer.
// The master modport is the surrounding system: the FIFO plus the word consumer.
// The slave modport is the packer itself.
interface cr_kme_flag_packer_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // FIFO head, pop handshake, error pulses and flush request
    logic             fifo_out;
    logic             fifo_out_valid;
    logic             fifo_out_ack;
    logic             fifo_overflow;
    logic             fifo_underflow;
    logic             flush;

    // Packed word output with valid/ready, flush completion and sticky errors
    logic [WIDTH-1:0] pack_data;
    logic [CNT_W-1:0] pack_count;
    logic             pack_valid;
    logic             pack_ready;
    logic             flush_done;
    logic [1:0]       err_sticky;

    modport master (
        output fifo_out,
        output fifo_out_valid,
        output fifo_overflow,
        output fifo_underflow,
        output flush,
        output pack_ready,
        input  fifo_out_ack,
        input  pack_data,
        input  pack_count,
        input  pack_valid,
        input  flush_done,
        input  err_sticky
    );

    modport slave (
        input  fifo_out,
        input  fifo_out_valid,
        input  fifo_overflow,
        input  fifo_underflow,
        input  flush,
        input  pack_ready,
        output fifo_out_ack,
        output pack_data,
        output pack_count,
        output pack_valid,
        output flush_done,
        output err_sticky
    );
endinterface

// File: rtl/cr_kme_flag_packer.sv
// Pops single-bit flags from the KME flag FIFO and packs them LSB-first into
// WIDTH-bit words. A flush emits any partial word zero-padded with its bit count.
// Overflow/underflow pulses from the FIFO are latched into sticky error bits.
module cr_kme_flag_packer #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cr_kme_flag_packer_if.slave    bus
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

    // ST_FLUSH means a flush request is pending and acks are blocked.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t           state_q, state_d;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [1:0]       err_q, err_d;

    logic             slot_free;
    logic             ack;
    logic             word_done;
    logic             flush_emit;
    logic [WIDTH-1:0] acc_masked;

    // Handshake decisions: the output slot is free when empty or being drained,
    // and the word-completing bit may only be popped into a free slot.
    always_comb begin
        slot_free  = !valid_q || bus.pack_ready;
        ack        = bus.fifo_out_valid && (state_q == ST_RUN) &&
                     ((cnt_q < LAST_IDX) || slot_free);
        word_done  = ack && (cnt_q == LAST_IDX);
        flush_emit = (state_q == ST_FLUSH) && (cnt_q != '0) && slot_free;
    end

    // Flush FSM next state; a flush arriving while one is pending is ignored.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else if (slot_free) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Flush FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator and output-word next values: complete a word, append a bit,
    // or emit the partial word on flush; otherwise hold until accepted.
    always_comb begin
        acc_masked = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc_masked[i] = acc_q[i] && (CNT_W'(i) < cnt_q);
        end

        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        count_d = count_q;
        valid_d = valid_q && !bus.pack_ready;

        if (word_done) begin
            data_d  = {bus.fifo_out, acc_q[WIDTH-2:0]};
            count_d = FULL_CNT;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (ack) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (CNT_W'(i) == cnt_q) begin
                    acc_d[i] = bus.fifo_out;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end else if (flush_emit) begin
            data_d  = acc_masked;
            count_d = cnt_q;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
        end

        err_d = err_q | {bus.fifo_overflow, bus.fifo_underflow};
    end

    // Accumulator registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Output word register, flush completion pulse and sticky error bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.fifo_out_ack = ack;
    assign bus.pack_data    = data_q;
    assign bus.pack_count   = count_q;
    assign bus.pack_valid   = valid_q;
    assign bus.flush_done   = done_q;
    assign bus.err_sticky   = err_q;

endmodule
